// File: rtl/systolic_array_host_driver.sv
// Host-side sequencer for the systolic array's nibble-serial pins: buffers the
// operand matrices, streams them row-major on start and captures the result burst.
module systolic_array_host_driver #(
    parameter  int BITWIDTH = 4,
    parameter  int OUTWIDTH = 8,
    parameter  int N        = 2,
    parameter  int TIMEOUT  = 64,
    localparam int AW       = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [AW-1:0]       wr_addr,
    input  logic [BITWIDTH-1:0] wr_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic [AW-1:0]       rd_addr,
    output logic [OUTWIDTH-1:0] rd_data,
    output logic [BITWIDTH-1:0] sa_data,
    output logic                sa_load_weights,
    output logic                sa_load_inputs,
    output logic                sa_store_outputs,
    input  logic [OUTWIDTH-1:0] sa_results,
    input  logic                sa_valid_out
);
    localparam int unsigned     NN      = N * N;
    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST    = AW'(NN - 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_I,
        S_STORE,
        S_COLLECT
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_k;
    logic [TW-1:0]         r_to;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [BITWIDTH-1:0]   r_sa_data;
    logic                  r_sa_lw;
    logic                  r_sa_li;
    logic                  r_sa_so;
    logic [BITWIDTH-1:0]   r_wbuf [NN];
    logic [BITWIDTH-1:0]   r_ibuf [NN];
    logic [OUTWIDTH-1:0]   r_rbuf [NN];

    state_t                w_nxt_state;
    logic [AW-1:0]         w_nxt_k;
    logic [TW-1:0]         w_nxt_to;
    logic                  w_nxt_done;
    logic                  w_nxt_error;
    logic                  w_capture;
    logic [BITWIDTH-1:0]   w_nxt_data;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;

    generate
        if (NN == (1 << AW)) begin : g_pow2
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_npow2
            localparam logic [AW:0] NN_W = (AW + 1)'(NN);
            assign w_wr_in_range = ({1'b0, wr_addr} < NN_W);
            assign w_rd_in_range = ({1'b0, rd_addr} < NN_W);
        end
    endgenerate

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_k     = r_k;
        w_nxt_to    = r_to;
        w_nxt_done  = r_done;
        w_nxt_error = r_error;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_state = S_LOAD_W;
                    w_nxt_k     = '0;
                    w_nxt_done  = 1'b0;
                    w_nxt_error = 1'b0;
                end
            end
            S_LOAD_W: begin
                if (r_k == LAST) begin
                    w_nxt_state = S_LOAD_I;
                    w_nxt_k     = '0;
                end else begin
                    w_nxt_k = r_k + 1'b1;
                end
            end
            S_LOAD_I: begin
                if (r_k == LAST) begin
                    w_nxt_state = S_STORE;
                    w_nxt_k     = '0;
                end else begin
                    w_nxt_k = r_k + 1'b1;
                end
            end
            S_STORE: begin
                w_nxt_state = S_COLLECT;
                w_nxt_k     = '0;
                w_nxt_to    = '0;
            end
            S_COLLECT: begin
                if (sa_valid_out) begin
                    w_capture = 1'b1;
                    w_nxt_to  = '0;
                    if (r_k == LAST) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_k     = '0;
                        w_nxt_done  = 1'b1;
                    end else begin
                        w_nxt_k = r_k + 1'b1;
                    end
                end else if (r_to == TO_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_to    = '0;
                    w_nxt_error = 1'b1;
                end else begin
                    w_nxt_to = r_to + 1'b1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state/index so each strobe and its
    // nibble appear in the same cycle the FSM occupies that phase.
    always_comb begin
        w_nxt_data = '0;
        if (w_nxt_state == S_LOAD_W) begin
            w_nxt_data = r_wbuf[w_nxt_k];
        end else if (w_nxt_state == S_LOAD_I) begin
            w_nxt_data = r_ibuf[w_nxt_k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_to      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_sa_data <= '0;
            r_sa_lw   <= 1'b0;
            r_sa_li   <= 1'b0;
            r_sa_so   <= 1'b0;
            for (int unsigned i = 0; i < NN; i++) begin
                r_wbuf[i] <= '0;
                r_ibuf[i] <= '0;
                r_rbuf[i] <= '0;
            end
        end else begin
            r_state   <= w_nxt_state;
            r_k       <= w_nxt_k;
            r_to      <= w_nxt_to;
            r_busy    <= (w_nxt_state != S_IDLE);
            r_done    <= w_nxt_done;
            r_error   <= w_nxt_error;
            r_sa_data <= w_nxt_data;
            r_sa_lw   <= (w_nxt_state == S_LOAD_W);
            r_sa_li   <= (w_nxt_state == S_LOAD_I);
            r_sa_so   <= (w_nxt_state == S_STORE);
            if (wr_en && !r_busy && w_wr_in_range) begin
                if (wr_sel) begin
                    r_ibuf[wr_addr] <= wr_data;
                end else begin
                    r_wbuf[wr_addr] <= wr_data;
                end
            end
            if (w_capture) begin
                r_rbuf[r_k] <= sa_results;
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign sa_data          = r_sa_data;
    assign sa_load_weights  = r_sa_lw;
    assign sa_load_inputs   = r_sa_li;
    assign sa_store_outputs = r_sa_so;
    assign rd_data          = w_rd_in_range ? r_rbuf[rd_addr] : '0;

endmodule

// File: tb/tb_systolic_array_host_driver.sv
// Self-checking bench: cycle-numbered behavioural model of the host driver plus
// a reactive array stub that answers each store request with a result burst.
module tb_systolic_array_host_driver;
    localparam int BW = 4;
    localparam int OW = 8;
    localparam int N  = 2;
    localparam int TO = 64;
    localparam int NN = N * N;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] rd_addr;
    logic [OW-1:0] rd_data;
    logic [BW-1:0] sa_data;
    logic          sa_load_weights;
    logic          sa_load_inputs;
    logic          sa_store_outputs;
    logic [OW-1:0] sa_results;
    logic          sa_valid_out;

    always #5 clk = ~clk;

    systolic_array_host_driver #(
        .BITWIDTH(BW),
        .OUTWIDTH(OW),
        .N(N),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .busy(busy),
        .done(done),
        .error(error),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .sa_data(sa_data),
        .sa_load_weights(sa_load_weights),
        .sa_load_inputs(sa_load_inputs),
        .sa_store_outputs(sa_store_outputs),
        .sa_results(sa_results),
        .sa_valid_out(sa_valid_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (cycle number since start) ----------------
    bit            model_on = 1'b0;
    int            m_t;
    bit            m_busy, m_done, m_error;
    bit            m_lw, m_li, m_so;
    logic [BW-1:0] m_data;
    logic [BW-1:0] m_w [NN];
    logic [BW-1:0] m_i [NN];
    logic [OW-1:0] m_r [NN];
    int            m_cap, m_idle;

    always @(posedge clk) begin
        bit old_busy;
        if (rst) begin
            model_on = 1'b1;
            m_t = 0; m_busy = 0; m_done = 0; m_error = 0; m_cap = 0; m_idle = 0;
            for (int i = 0; i < NN; i++) begin
                m_w[i] = '0; m_i[i] = '0; m_r[i] = '0;
            end
        end else begin
            old_busy = m_busy;
            if (!m_busy) begin
                if (start) begin
                    m_t = 1; m_busy = 1; m_done = 0; m_error = 0; m_cap = 0; m_idle = 0;
                end
            end else if (m_t < 2 * NN + 2) begin
                m_t++;
            end else if (sa_valid_out) begin
                m_r[m_cap] = sa_results;
                m_cap++;
                m_idle = 0;
                if (m_cap == NN) begin
                    m_done = 1; m_busy = 0; m_t = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_error = 1; m_busy = 0; m_t = 0;
                end
            end
            if (!m_busy) m_t = 0;
        end
        m_lw   = (m_t >= 1 && m_t <= NN);
        m_li   = (m_t > NN && m_t <= 2 * NN);
        m_so   = (m_t == 2 * NN + 1);
        m_data = m_lw ? m_w[m_t - 1] : (m_li ? m_i[m_t - NN - 1] : '0);
        if (!rst && !old_busy && wr_en) begin
            if (wr_sel) m_i[wr_addr] = wr_data;
            else        m_w[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("error", error, m_error);
            chk("sa_load_weights", sa_load_weights, m_lw);
            chk("sa_load_inputs", sa_load_inputs, m_li);
            chk("sa_store_outputs", sa_store_outputs, m_so);
            chk("sa_data", sa_data, m_data);
            chk("rd_data", rd_data, m_r[rd_addr]);
        end
    end

    // ---------------- array stub ----------------
    typedef struct packed {logic v; logic [OW-1:0] d;} beat_t;
    beat_t         rsp_q[$];
    bit            rsp_pat[$];
    logic [OW-1:0] rsp_vals [NN];
    int            rsp_delay = 0;
    int            rsp_limit = NN;
    bit            junk = 1'b0;
    bit            rd_rand = 1'b0;

    always @(negedge clk) begin
        if (sa_store_outputs === 1'b1) begin
            int idx;
            int pi;
            beat_t b;
            rsp_q.delete();
            for (int d = 0; d < rsp_delay; d++) begin
                b.v = 1'b0; b.d = OW'($urandom);
                rsp_q.push_back(b);
            end
            idx = 0; pi = 0;
            while (idx < rsp_limit) begin
                b.v = (pi < rsp_pat.size()) ? rsp_pat[pi] : 1'b1;
                pi++;
                if (b.v) begin
                    b.d = rsp_vals[idx];
                    idx++;
                end else begin
                    b.d = OW'($urandom);
                end
                rsp_q.push_back(b);
            end
        end
    end

    initial begin
        beat_t b;
        sa_valid_out = 1'b0;
        sa_results   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_q.size() > 0) begin
                b = rsp_q.pop_front();
                sa_valid_out = b.v;
                sa_results   = b.d;
            end else begin
                sa_valid_out = junk ? 1'(($urandom)) : 1'b0;
                sa_results   = OW'($urandom);
            end
            if (rd_rand) rd_addr = AW'($urandom);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [BW-1:0] cur_w [NN];
    logic [BW-1:0] cur_i [NN];

    function automatic logic [OW-1:0] mm(input int r, input int c);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(cur_w[r * N + k]) * int'(cur_i[k * N + c]);
        return OW'(s);
    endfunction

    task automatic wr(input bit sel, input int a, input int d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(a); wr_data = BW'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_ops();
        for (int a = 0; a < NN; a++) begin
            wr(1'b0, a, int'(cur_w[a]));
            wr(1'b1, a, int'(cur_i[a]));
        end
        for (int a = 0; a < NN; a++) rsp_vals[a] = mm(a / N, a % N);
    endtask

    task automatic pulse_start(input bit with_wr);
        start = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_sel = 1'($urandom); wr_addr = AW'($urandom); wr_data = BW'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int base, input int budget, output int cyc);
        cyc = base;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b0) break;
        end
        chk("wait_idle_bound", busy, 0);
    endtask

    task automatic read_chk(input string name, input int a, input logic [OW-1:0] exp);
        rd_rand = 1'b0;
        @(posedge clk); #1;
        rd_addr = AW'(a);
        @(negedge clk);
        chk(name, rd_data, exp);
    endtask

    logic [BW-1:0] seq_d  [9];
    logic          seq_lw [9];
    logic          seq_li [9];
    logic          seq_so [9];
    logic [OW-1:0] prev_vals [NN];
    int            cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_sa_data", sa_data, 0);
        chk("reset_rd_data", rd_data, 0);

        // Directed run: weights 1..4, inputs 5..8, results 3 cycles after store.
        cur_w = '{4'd1, 4'd2, 4'd3, 4'd4};
        cur_i = '{4'd5, 4'd6, 4'd7, 4'd8};
        load_ops();
        rsp_pat.delete(); rsp_delay = 2; rsp_limit = NN;
        pulse_start(1'b0);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            seq_d[c] = sa_data; seq_lw[c] = sa_load_weights;
            seq_li[c] = sa_load_inputs; seq_so[c] = sa_store_outputs;
        end
        for (int c = 0; c < 8; c++) begin
            chk("seq_data", seq_d[c], c + 1);
            chk("seq_lw", seq_lw[c], (c < 4) ? 1 : 0);
            chk("seq_li", seq_li[c], (c >= 4) ? 1 : 0);
            chk("seq_so_low", seq_so[c], 0);
        end
        chk("store_cycle9", seq_so[8], 1);
        chk("store_cycle9_data", seq_d[8], 0);
        wait_idle(9, 100, cyc);
        chk("done_cycle", cyc, 16);
        chk("dir_done", done, 1);
        chk("dir_busy", busy, 0);
        read_chk("dir_r0", 0, 8'd19);
        read_chk("dir_r1", 1, 8'd22);
        read_chk("dir_r2", 2, 8'd43);
        read_chk("dir_r3", 3, 8'd50);

        // Gapped burst 1,0,0,1,1,0,1.
        for (int a = 0; a < NN; a++) rsp_vals[a] = OW'($urandom);
        rsp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rsp_delay = 0;
        pulse_start(1'b0);
        wait_idle(0, 100, cyc);
        chk("gap_done_cycle", cyc, 17);
        chk("gap_done", done, 1);
        for (int a = 0; a < NN; a++) read_chk("gap_rd", a, rsp_vals[a]);
        for (int a = 0; a < NN; a++) prev_vals[a] = rsp_vals[a];

        // Timeout with two results only.
        for (int a = 0; a < NN; a++) rsp_vals[a] = OW'($urandom);
        rsp_pat.delete(); rsp_delay = 1; rsp_limit = 2;
        pulse_start(1'b0);
        wait_idle(0, 200, cyc);
        chk("timeout_cycle", cyc, 77);
        chk("timeout_error", error, 1);
        chk("timeout_done", done, 0);
        read_chk("to_r0", 0, rsp_vals[0]);
        read_chk("to_r1", 1, rsp_vals[1]);
        read_chk("to_r2", 2, prev_vals[2]);
        read_chk("to_r3", 3, prev_vals[3]);

        // start and wr_en during LOAD_I, junk valids outside COLLECT.
        for (int a = 0; a < NN; a++) begin
            cur_w[a] = BW'($urandom); cur_i[a] = BW'($urandom);
        end
        load_ops();
        rsp_limit = NN; rsp_delay = 1;
        pulse_start(1'b0);
        junk = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom); wr_addr = AW'($urandom); wr_data = BW'($urandom);
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        junk = 1'b0;
        wait_idle(8, 100, cyc);
        chk("ovl_done", done, 1);
        pulse_start(1'b0);
        @(negedge clk);
        chk("rerun_done_cleared", done, 0);
        chk("rerun_busy", busy, 1);
        wait_idle(1, 100, cyc);
        chk("rerun_done", done, 1);
        for (int a = 0; a < NN; a++) read_chk("rerun_rd", a, rsp_vals[a]);

        // Reset during LOAD_W cycle 2.
        pulse_start(1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_lw", sa_load_weights, 0);
        chk("rst_li", sa_load_inputs, 0);
        chk("rst_so", sa_store_outputs, 0);
        chk("rst_data", sa_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        for (int a = 0; a < NN; a++) read_chk("rst_rd", a, 0);

        // Randomised back-to-back runs.
        rd_rand = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < NN; a++) begin
                cur_w[a] = BW'($urandom); cur_i[a] = BW'($urandom);
            end
            load_ops();
            rd_rand = 1'b1;
            rsp_pat.delete();
            for (int p = 0; p < int'($urandom_range(0, 6)); p++) rsp_pat.push_back($urandom_range(0, 2) != 0);
            rsp_delay = $urandom_range(0, 4);
            rsp_limit = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NN - 1) : NN;
            pulse_start(1'($urandom_range(0, 1)));
            wait_idle(0, 300, cyc);
            chk("rand_done", done, (rsp_limit == NN) ? 1 : 0);
            chk("rand_error", error, (rsp_limit == NN) ? 0 : 1);
            repeat (2) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_host_driver.md
# systolic_array_host_driver

Host-side sequencer for the systolic array multiplier's nibble-serial pin interface. It buffers one weight matrix and one input matrix written by the host. On `start` it drives the array's `load_weights`, `load_inputs` and `store_outputs` controls with row-major nibbles on the shared data bus. It then captures the returned `valid_out`/`results` stream into a readable result buffer. It sits between the test/host logic and the array's top-level pins.

## Interface
- `BITWIDTH`, 4: operand width; width of the array's data bus.
- `OUTWIDTH`, 8: result width from the array.
- `N`, 2: array dimension; each matrix holds `N*N` elements.
- `TIMEOUT`, 64: maximum idle cycles in result collection before error.
- `AW` (derived): `$clog2(N*N)`, minimum 1.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe into the operand buffers.
- `wr_sel`  in  1  0 = weight buffer, 1 = input buffer.
- `wr_addr`  in  AW  row-major element index.
- `wr_data`  in  BITWIDTH  element value.
- `start`  in  1  one-cycle request to run one multiply.
- `busy`  out  1  high from the cycle after an accepted `start` until completion or error.
- `done`  out  1  sticky; set on successful completion, cleared by the next accepted `start` or by `rst`.
- `error`  out  1  sticky timeout flag; cleared the same way as `done`.
- `rd_addr`  in  AW  result buffer index.
- `rd_data`  out  OUTWIDTH  combinational read of result buffer `[rd_addr]`.
- `sa_data`  out  BITWIDTH  nibble bus to the array.
- `sa_load_weights`  out  1  weight load strobe.
- `sa_load_inputs`  out  1  input load strobe.
- `sa_store_outputs`  out  1  result request pulse.
- `sa_results`  in  OUTWIDTH  result bus from the array.
- `sa_valid_out`  in  1  result-valid qualifier from the array.

## Operation
- Buffers:
  - Weight and input buffers are `N*N` x `BITWIDTH` registers; the result buffer is `N*N` x `OUTWIDTH`. `rst` clears all three to 0.
  - Writes with `wr_en`=1 are accepted only when `busy`=0 and are ignored while busy.
  - Out-of-range `wr_addr` values (when `N*N` is not a power of 2) are ignored.
- FSM states: IDLE, LOAD_W, LOAD_I, STORE, COLLECT.
  - IDLE: `start`=1 clears `done`/`error`, zeroes the element counter `k`, and moves to LOAD_W. `start` in any other state is ignored.
  - LOAD_W: `sa_load_weights`=1, `sa_data`=weight[k], `k`++. After element `N*N-1`, `k` returns to 0 and the FSM moves to LOAD_I.
  - LOAD_I: `sa_load_inputs`=1, `sa_data`=input[k], `k`++. After the last element, the FSM moves to STORE.
  - STORE: `sa_store_outputs`=1 for exactly one cycle, then COLLECT with `k`=0 and the timeout counter at 0.
  - COLLECT: each cycle with `sa_valid_out`=1 writes result[k]=`sa_results`, increments `k` and zeroes the timeout counter.
    - Capturing element `N*N-1` sets `done` and returns to IDLE.
    - Each cycle with `sa_valid_out`=0 increments the timeout counter. When the counter reaches `TIMEOUT`, the FSM sets `error` and returns to IDLE, and the result buffer keeps the partial data.
- Gaps in `sa_valid_out` mid-burst are legal and are waited through.
- `sa_valid_out` outside COLLECT is ignored.
- Strobes are mutually exclusive. `sa_data`=0 whenever neither load strobe is high.
- All `sa_*` outputs, `busy`, `done` and `error` are registered.

## Timing
- Reset values: `busy`, `done`, `error`, `sa_load_weights`, `sa_load_inputs`, `sa_store_outputs` are 0; `sa_data` is 0; FSM is IDLE; `k` and the timeout counter are 0.
- `start` sampled at edge 0:
  - LOAD_W strobes occupy cycles 1..`N*N`.
  - LOAD_I strobes occupy cycles `N*N+1`..`2N*N`.
  - `sa_store_outputs` is high in cycle `2N*N+1`.
  - COLLECT begins at cycle `2N*N+2`.
- `busy` is high from cycle 1 through the last COLLECT cycle and falls in the same cycle that `done` or `error` rises.
- Results land in the buffer at the edge where `sa_valid_out` is sampled and are readable through `rd_data` on the following cycle.
- `rst` mid-operation: on the next edge, all strobes drop and the FSM returns to IDLE with all flags and buffers cleared. No partial sequence resumes.
- `start` together with `wr_en` in IDLE: the write is accepted, and the sequence uses the pre-write buffer contents only if the written element was already streamed. Host software must not issue writes together with `start`.

## Test plan
- N=2, weights [1,2,3,4], inputs [5,6,7,8], array model answering 3 cycles after STORE with four consecutive results [19,22,43,50].
  - Required: `sa_data` sequence 1,2,3,4,5,6,7,8 under the correct strobes, `sa_store_outputs` high in cycle 9, `done`=1, `busy`=0, `rd_data` at addr 0..3 = 19,22,43,50.
- Gapped results: `sa_valid_out` pattern 1,0,0,1,1,0,1.
  - Required: all four results captured in order and `done` set one cycle after the last valid.
- Timeout with TIMEOUT=64 and only 2 valid results returned.
  - Required: `error`=1 exactly 64 idle cycles after the second capture, `done`=0, result[0..1] written, result[2..3] unchanged.
- `start` and `wr_en` pulsed during LOAD_I.
  - Required: sequence unaffected and buffer contents unchanged. A fresh `start` after `done` clears `done` and reruns the sequence.
- `rst` asserted during LOAD_W cycle 2.
  - Required: next cycle all `sa_*` strobes 0, `busy`/`done`/`error` 0, buffers read 0.
- Back-to-back runs with different weights.
  - Required: second-run results overwrite the first and `done` re-asserts.
